cdb_writeback: RTL and testbench

Common-data-bus writeback stage for the Tomasulo core: round-robin arbitration of one completed functional-unit result per cycle, registered CDB broadcast to the reservation stations, and a register-status (Qi) table deciding whether the broadcast commits to the architectural register file. It is the write side of the register file, driving its write address, write data and write enable, and serves issue-time "which tag produces rN" lookups.

---
 rtl/cdb_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/cdb_writeback.sv | 114 +++++++++++
 tb/tb_cdb_writeback.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared constants and tag type for the CDB writeback stage
package cdb_pkg;

  localparam int N_FU  = 4;
  localparam int TAG_W = 4;

  typedef logic [TAG_W-1:0] tag_t;

  // Tag value meaning "no producer pending, register value is ready".
  localparam tag_t NO_TAG = '0;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotating-priority arbiter, search starts one past the last grant
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  // Walk ptr+1, ptr+2, ... ptr (mod N) and grant the first requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any_grant && req[(int'(ptr) + k) % N]) begin
        any_grant                     = 1'b1;
        grant[(int'(ptr) + k) % N]    = 1'b1;
        grant_idx                     = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/cdb_writeback.sv
// rtl/cdb_writeback.sv - CDB arbitration, broadcast register and Qi register-status table
module cdb_writeback
  import cdb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [N_FU-1:0]         fu_valid,
  output logic [N_FU-1:0]         fu_ready,
  input  logic [N_FU*TAG_W-1:0]   fu_tag,
  input  logic [N_FU*32-1:0]      fu_data,
  input  logic                    issue_en,
  input  logic [4:0]              issue_rd,
  input  tag_t                    issue_tag,
  input  logic [4:0]              qi_addr_A,
  input  logic [4:0]              qi_addr_B,
  output tag_t                    qi_A,
  output tag_t                    qi_B,
  output logic                    cdb_valid,
  output tag_t                    cdb_tag,
  output logic [31:0]             cdb_data,
  output logic [4:0]              Wt_addr,
  output logic [31:0]             Wt_data,
  output logic                    EN
);

  localparam int IDX_W = (N_FU > 1) ? $clog2(N_FU) : 1;

  // r0 has no entry: it never has a producer.
  tag_t              qi [1:31];

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  gnt_idx;
  logic [N_FU-1:0]   gnt;
  logic              gnt_any;
  logic              blocked;
  logic              xfer;
  tag_t              sel_tag;
  logic [31:0]       sel_data;
  logic              match;
  logic [4:0]        match_rd;

  rr_arbiter #(.N(N_FU), .IW(IDX_W)) u_arb (
    .req       (fu_valid),
    .ptr       (ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .any_grant (gnt_any)
  );

  // Reset and flush withhold the grant so the source keeps its result and retries.
  assign blocked  = rst | flush;
  assign fu_ready = blocked ? '0 : gnt;
  assign xfer     = gnt_any & ~blocked;

  assign sel_tag  = fu_tag[gnt_idx*TAG_W +: TAG_W];
  assign sel_data = fu_data[gnt_idx*32 +: 32];

  assign qi_A = (qi_addr_A == 5'd0) ? NO_TAG : qi[qi_addr_A];
  assign qi_B = (qi_addr_B == 5'd0) ? NO_TAG : qi[qi_addr_B];

  // Lowest register waiting on the broadcast tag; no match means a WAW-superseded result.
  always_comb begin
    match    = 1'b0;
    match_rd = 5'd0;
    for (int r = 31; r >= 1; r--) begin
      if (sel_tag != NO_TAG && qi[r] == sel_tag) begin
        match    = 1'b1;
        match_rd = 5'(r);
      end
    end
  end

  // Qi table: clear on commit, then a same-cycle issue to that register overrides the clear.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int r = 1; r <= 31; r++) qi[r] <= NO_TAG;
    end else begin
      if (xfer && match) qi[match_rd] <= NO_TAG;
      if (issue_en && issue_rd != 5'd0) qi[issue_rd] <= issue_tag;
    end
  end

  // Broadcast and register-file write port; tag/data/address hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= NO_TAG;
      cdb_data  <= '0;
      EN        <= 1'b0;
      Wt_addr   <= '0;
      Wt_data   <= '0;
      ptr       <= IDX_W'(N_FU - 1);
    end else if (flush) begin
      cdb_valid <= 1'b0;
      EN        <= 1'b0;
      ptr       <= IDX_W'(N_FU - 1);
    end else if (xfer) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= sel_tag;
      cdb_data  <= sel_data;
      EN        <= match;
      ptr       <= gnt_idx;
      if (match) begin
        Wt_addr <= match_rd;
        Wt_data <= sel_data;
      end
    end else begin
      cdb_valid <= 1'b0;
      EN        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_writeback.sv
// tb/tb_cdb_writeback.sv - directed and randomized checks of cdb_writeback against a reference model
module tb_cdb_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [3:0]  fu_valid;
  logic [3:0]  fu_ready;
  logic [15:0] fu_tag;
  logic [127:0] fu_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_tag;
  logic [4:0]  qi_addr_A;
  logic [4:0]  qi_addr_B;
  logic [3:0]  qi_A;
  logic [3:0]  qi_B;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [4:0]  Wt_addr;
  logic [31:0] Wt_data;
  logic        EN;

  cdb_writeback dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_tag(fu_tag), .fu_data(fu_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .qi_addr_A(qi_addr_A), .qi_addr_B(qi_addr_B), .qi_A(qi_A), .qi_B(qi_B),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .Wt_addr(Wt_addr), .Wt_data(Wt_data), .EN(EN)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: what each register is waiting for, and the last-granted source.
  logic [3:0]  mqi [32];
  int          mptr;
  int          last_gi;
  logic        e_cv, e_en;
  logic [3:0]  e_tag;
  logic [31:0] e_data, e_wdata;
  logic [4:0]  e_addr;

  // Random-phase source state.
  logic        fv [4];
  logic [3:0]  ft [4];
  logic [31:0] fd [4];
  logic        used [16];
  int          pq [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    flush    = 1'b0;
    fu_valid = '0;
    fu_tag   = '0;
    fu_data  = '0;
    issue_en = 1'b0;
    issue_rd = '0;
    issue_tag = '0;
  endtask

  task automatic set_fu(input int i, input logic [3:0] t, input logic [31:0] d);
    fu_valid[i]      = 1'b1;
    fu_tag[i*4 +: 4] = t;
    fu_data[i*32 +: 32] = d;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    int gi;
    int fr;
    logic [3:0]  t;
    logic [31:0] d;
    #1;
    gi = -1;
    if (!rst && !flush)
      for (int k = 1; k <= 4; k++)
        if (gi < 0 && fu_valid[(mptr + k) % 4]) gi = (mptr + k) % 4;
    check("fu_ready", 64'(fu_ready), (gi < 0) ? 64'd0 : (64'd1 << gi));
    if (!rst) begin
      check("qi_A", 64'(qi_A), 64'(mqi[qi_addr_A]));
      check("qi_B", 64'(qi_B), 64'(mqi[qi_addr_B]));
    end
    if (rst || flush) begin
      for (int r = 0; r < 32; r++) mqi[r] = 4'd0;
      mptr = 3;
      e_cv = 1'b0;
      e_en = 1'b0;
      if (rst) begin
        e_tag = '0; e_data = '0; e_addr = '0; e_wdata = '0;
      end
    end else begin
      if (gi >= 0) begin
        t = fu_tag[gi*4 +: 4];
        d = fu_data[gi*32 +: 32];
        e_cv = 1'b1; e_tag = t; e_data = d; e_en = 1'b0;
        fr = 0;
        for (int r = 1; r < 32; r++) if (fr == 0 && mqi[r] == t) fr = r;
        if (fr != 0) begin
          e_en = 1'b1; e_addr = 5'(fr); e_wdata = d; mqi[fr] = 4'd0;
        end
        mptr = gi;
      end else begin
        e_cv = 1'b0;
        e_en = 1'b0;
      end
      if (issue_en && issue_rd != 5'd0) mqi[issue_rd] = issue_tag;
    end
    last_gi = gi;
    @(posedge clk);
    #1;
    check("cdb_valid", 64'(cdb_valid), 64'(e_cv));
    check("cdb_tag",   64'(cdb_tag),   64'(e_tag));
    check("cdb_data",  64'(cdb_data),  64'(e_data));
    check("EN",        64'(EN),        64'(e_en));
    check("Wt_addr",   64'(Wt_addr),   64'(e_addr));
    check("Wt_data",   64'(Wt_data),   64'(e_wdata));
  endtask

  task automatic peek_qi(input string tag, input logic [4:0] a, input logic [3:0] exp);
    qi_addr_A = a;
    #1;
    check(tag, 64'(qi_A), 64'(exp));
  endtask

  initial begin
    int tt, start, idx;
    for (int r = 0; r < 32; r++) mqi[r] = 4'd0;
    mptr = 3;
    idle_inputs();
    qi_addr_A = 5'd0;
    qi_addr_B = 5'd0;
    rst = 1'b1;
    @(posedge clk); #1;
    fu_valid = 4'hF;
    step();
    step();
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) step();
    for (int a = 0; a < 32; a++) peek_qi("reset_qi", 5'(a), 4'd0);
    check("reset_ready", 64'(fu_ready), 64'd0);

    // Simple issue then completion from FU1.
    issue_en = 1'b1; issue_rd = 5'd5; issue_tag = 4'd3;
    step();
    idle_inputs();
    set_fu(1, 4'd3, 32'hDEADBEEF);
    step();
    check("basic_en", 64'(EN), 64'd1);
    check("basic_addr", 64'(Wt_addr), 64'd5);
    check("basic_data", 64'(Wt_data), 64'hDEADBEEF);
    idle_inputs();
    peek_qi("basic_qi5", 5'd5, 4'd0);

    // WAW: older tag completes without writing.
    issue_en = 1'b1; issue_rd = 5'd7; issue_tag = 4'd2;
    step();
    issue_tag = 4'd4;
    step();
    idle_inputs();
    set_fu(0, 4'd2, 32'h11112222);
    step();
    check("waw_old_cv", 64'(cdb_valid), 64'd1);
    check("waw_old_en", 64'(EN), 64'd0);
    idle_inputs();
    peek_qi("waw_qi7", 5'd7, 4'd4);
    set_fu(0, 4'd4, 32'h33334444);
    step();
    check("waw_new_en", 64'(EN), 64'd1);
    check("waw_new_addr", 64'(Wt_addr), 64'd7);

    // Round-robin from the post-flush pointer.
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) set_fu(i, 4'(i + 10), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rr_grant", 64'(fu_ready), 64'd1 << (i % 4));
      step();
      check("rr_tag", 64'(cdb_tag), 64'((i % 4) + 10));
    end

    // Issue and commit to the same register in one cycle.
    idle_inputs();
    issue_en = 1'b1; issue_rd = 5'd9; issue_tag = 4'd6;
    step();
    set_fu(2, 4'd6, 32'h5555AAAA);
    issue_tag = 4'd8;
    step();
    check("same_en", 64'(EN), 64'd1);
    check("same_addr", 64'(Wt_addr), 64'd9);
    idle_inputs();
    peek_qi("same_qi9", 5'd9, 4'd8);

    // Flush with a pending result.
    issue_en = 1'b1; issue_rd = 5'd3; issue_tag = 4'd5;
    step();
    idle_inputs();
    set_fu(0, 4'd5, 32'h77778888);
    flush = 1'b1;
    #1;
    check("flush_ready", 64'(fu_ready), 64'd0);
    step();
    check("flush_cv", 64'(cdb_valid), 64'd0);
    flush = 1'b0;
    set_fu(1, 4'd12, 32'h0);
    peek_qi("flush_qi3", 5'd3, 4'd0);
    check("flush_first", 64'(fu_ready), 64'd1);
    step();

    // Randomized traffic with unique in-flight tags.
    idle_inputs();
    flush = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin fv[i] = 1'b0; ft[i] = '0; fd[i] = '0; end
    for (int i = 0; i < 16; i++) used[i] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        fu_valid[i] = fv[i];
        fu_tag[i*4 +: 4] = ft[i];
        fu_data[i*32 +: 32] = fd[i];
      end
      issue_en = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        start = $urandom_range(1, 15);
        tt = 0;
        for (int k = 0; k < 15; k++)
          if (tt == 0 && !used[1 + ((start - 1 + k) % 15)]) tt = 1 + ((start - 1 + k) % 15);
        if (tt != 0) begin
          used[tt]  = 1'b1;
          issue_en  = 1'b1;
          issue_rd  = 5'($urandom_range(0, 31));
          issue_tag = 4'(tt);
          pq.push_back(tt);
        end
      end
      flush = ($urandom_range(0, 59) == 0);
      qi_addr_A = 5'($urandom_range(0, 31));
      qi_addr_B = 5'($urandom_range(0, 31));
      step();
      if (last_gi >= 0) begin
        used[ft[last_gi]] = 1'b0;
        fv[last_gi] = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (!fv[i] && pq.size() > 0 && $urandom_range(0, 3) != 0) begin
          idx = $urandom_range(0, pq.size() - 1);
          ft[i] = 4'(pq[idx]);
          fd[i] = $urandom;
          fv[i] = 1'b1;
          pq.delete(idx);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
